// File: rtl/lcd1602_pkg.sv
// Shared constants, types and address helpers for the LCD1602 bus responder.
package lcd1602_pkg;

    // DDRAM address map: line 1 is 0x00-0x27, line 2 is 0x40-0x67
    localparam logic [6:0] DDRAM_LINE1_END  = 7'h27;
    localparam logic [6:0] DDRAM_LINE2_BASE = 7'h40;
    localparam logic [6:0] DDRAM_LINE2_END  = 7'h67;
    localparam int         DDRAM_DEPTH      = 80;
    localparam logic [6:0] DDRAM_LAST_IDX   = 7'd79;
    localparam logic [6:0] DDRAM_BAD_IDX    = 7'h7F;

    // Character written everywhere by Clear Display
    localparam logic [7:0] SPACE_CODE = 8'h20;

    // Instruction opcodes are identified by their leading one bit
    localparam logic [7:0] OP_CLEAR_MASK   = 8'h01;
    localparam logic [7:0] OP_HOME_MASK    = 8'h02;
    localparam logic [7:0] OP_ENTRY_MASK   = 8'h04;
    localparam logic [7:0] OP_DISPLAY_MASK = 8'h08;
    localparam logic [7:0] OP_SHIFT_MASK   = 8'h10;
    localparam logic [7:0] OP_FUNC_MASK    = 8'h20;
    localparam logic [7:0] OP_CGRAM_MASK   = 8'h40;
    localparam logic [7:0] OP_DDRAM_MASK   = 8'h80;

    typedef enum logic [1:0] {
        WAIT_E,
        E_HIGH,
        EXEC
    } bus_state_t;

    typedef enum logic [3:0] {
        INS_NONE,
        INS_CLEAR,
        INS_HOME,
        INS_ENTRY,
        INS_DISPLAY,
        INS_SHIFT,
        INS_FUNC,
        INS_CGRAM,
        INS_DDRAM
    } opcode_t;

    function automatic opcode_t decode_op(input logic [7:0] cmd);
        if ((cmd & OP_DDRAM_MASK) != 8'h00)        return INS_DDRAM;
        else if ((cmd & OP_CGRAM_MASK) != 8'h00)   return INS_CGRAM;
        else if ((cmd & OP_FUNC_MASK) != 8'h00)    return INS_FUNC;
        else if ((cmd & OP_SHIFT_MASK) != 8'h00)   return INS_SHIFT;
        else if ((cmd & OP_DISPLAY_MASK) != 8'h00) return INS_DISPLAY;
        else if ((cmd & OP_ENTRY_MASK) != 8'h00)   return INS_ENTRY;
        else if ((cmd & OP_HOME_MASK) != 8'h00)    return INS_HOME;
        else if ((cmd & OP_CLEAR_MASK) != 8'h00)   return INS_CLEAR;
        else                                       return INS_NONE;
    endfunction

    function automatic logic ddram_legal(input logic [6:0] addr);
        return (addr <= DDRAM_LINE1_END) ||
               ((addr >= DDRAM_LINE2_BASE) && (addr <= DDRAM_LINE2_END));
    endfunction

    // Packs the two 40-character lines into physical rows 0..79
    function automatic logic [6:0] ddram_index(input logic [6:0] addr);
        if (addr <= DDRAM_LINE1_END)
            return addr;
        else if (ddram_legal(addr))
            return addr - 7'h18;
        else
            return DDRAM_BAD_IDX;
    endfunction

    // Address counter step that hops the gaps between the two lines
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == DDRAM_LINE1_END)      return DDRAM_LINE2_BASE;
            else if (ac == DDRAM_LINE2_END) return 7'h00;
            else                            return ac + 7'd1;
        end else begin
            if (ac == 7'h00)                 return DDRAM_LINE2_END;
            else if (ac == DDRAM_LINE2_BASE) return DDRAM_LINE1_END;
            else                             return ac - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd1602_ddram.sv
// 80x8 display data RAM: one bus read/write port and one registered read-only mirror port.
module lcd1602_ddram
    import lcd1602_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [6:0] idx,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic [6:0] dbg_idx,
    output logic [7:0] dbg_data
);

    logic [7:0] mem [0:DDRAM_DEPTH-1];

    // Bus-side write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we && (idx <= DDRAM_LAST_IDX))
            mem[idx] <= wdata;
    end

    assign rdata = (idx <= DDRAM_LAST_IDX) ? mem[idx] : 8'h00;

    // Mirror port for inspection, one cycle of latency
    always_ff @(posedge clk) begin
        if (rst)
            dbg_data <= 8'h00;
        else if (dbg_idx <= DDRAM_LAST_IDX)
            dbg_data <= mem[dbg_idx];
        else
            dbg_data <= 8'h00;
    end

endmodule

// File: rtl/lcd1602_responder.sv
// Behavioural HD44780-style LCD1602 bus responder: decodes E/RS/RW/DB transfers,
// maintains AC/BF/mode state and a DDRAM mirror.
module lcd1602_responder
    import lcd1602_pkg::*;
#(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 76000   // must be >= 80 so the clear sweep finishes while busy
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs,
    input  logic       rw,
    input  logic       e,
    input  logic [3:0] db_i,
    output logic [3:0] db_o,
    output logic       db_oe,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       viol
);

    localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

    logic       e_q1, e_q2, e_d;
    logic       rs_q1, rs_q2;
    logic       rw_q1, rw_q2;
    logic [3:0] db_q1, db_q2;
    logic       e_rise, e_fall;

    bus_state_t state, state_nx;

    logic             nib_low;
    logic [3:0]       hi_nib;
    logic [7:0]       cmd;
    logic             cmd_rs, cmd_rw;
    logic             dl, id;
    logic [2:0]       dcb;
    logic [6:0]       ac;
    logic [CNT_W-1:0] busy_cnt;
    logic             bf;
    logic             clr_active;
    logic [6:0]       clr_idx;
    opcode_t          op;

    logic       ram_we;
    logic [6:0] ram_idx;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic [7:0] rd_byte;

    // Two-flop synchronizer for the asynchronous bus, plus a delayed E for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q1  <= 1'b0; e_q2  <= 1'b0; e_d <= 1'b0;
            rs_q1 <= 1'b0; rs_q2 <= 1'b0;
            rw_q1 <= 1'b0; rw_q2 <= 1'b0;
            db_q1 <= 4'h0; db_q2 <= 4'h0;
        end else begin
            e_q1  <= e;     e_q2  <= e_q1;  e_d <= e_q2;
            rs_q1 <= rs;    rs_q2 <= rs_q1;
            rw_q1 <= rw;    rw_q2 <= rw_q1;
            db_q1 <= db_i;  db_q2 <= db_q1;
        end
    end

    assign e_rise = e_q2 & ~e_d;
    assign e_fall = ~e_q2 & e_d;
    assign bf     = (busy_cnt != '0);
    assign op     = decode_op(cmd);

    // Bus FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= WAIT_E;
        else
            state <= state_nx;
    end

    // Bus FSM next state: a byte completes on the E fall in 8-bit mode or on the low nibble
    always_comb begin
        state_nx = state;
        case (state)
            WAIT_E: if (e_rise) state_nx = E_HIGH;
            E_HIGH: if (e_fall) state_nx = (dl || nib_low) ? EXEC : WAIT_E;
            EXEC:   state_nx = WAIT_E;
            default: state_nx = WAIT_E;
        endcase
    end

    // Transfer capture, instruction/data execution, busy timer and clear sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            nib_low    <= 1'b0;
            hi_nib     <= 4'h0;
            cmd        <= 8'h00;
            cmd_rs     <= 1'b0;
            cmd_rw     <= 1'b0;
            dl         <= 1'b1;
            id         <= 1'b1;
            dcb        <= 3'b000;
            ac         <= 7'h00;
            busy_cnt   <= '0;
            viol       <= 1'b0;
            clr_active <= 1'b0;
            clr_idx    <= 7'h00;
        end else begin
            if (bf)
                busy_cnt <= busy_cnt - CNT_ONE;

            if (clr_active) begin
                clr_idx <= clr_idx + 7'd1;
                if (clr_idx == DDRAM_LAST_IDX)
                    clr_active <= 1'b0;
            end

            if ((state == E_HIGH) && e_fall) begin
                if (dl) begin
                    cmd    <= {db_q2, 4'h0};
                    cmd_rs <= rs_q2;
                    cmd_rw <= rw_q2;
                end else if (!nib_low) begin
                    hi_nib  <= db_q2;
                    nib_low <= 1'b1;
                end else begin
                    cmd     <= {hi_nib, db_q2};
                    cmd_rs  <= rs_q2;
                    cmd_rw  <= rw_q2;
                    nib_low <= 1'b0;
                end
            end

            if (state == EXEC) begin
                if (!cmd_rw && bf) begin
                    viol <= 1'b1;
                end else if (!cmd_rw && !cmd_rs) begin
                    busy_cnt <= BUSY_LOAD;
                    case (op)
                        INS_DDRAM: begin
                            if (ddram_legal(cmd[6:0])) begin
                                ac <= cmd[6:0];
                            end else begin
                                ac   <= 7'h00;
                                viol <= 1'b1;
                            end
                        end
                        INS_FUNC: begin
                            dl      <= cmd[4];
                            nib_low <= 1'b0;
                        end
                        INS_SHIFT: begin
                            if (!cmd[3])
                                ac <= ac_step(ac, cmd[2]);
                        end
                        INS_DISPLAY: dcb <= cmd[2:0];
                        INS_ENTRY:   id  <= cmd[1];
                        INS_HOME: begin
                            ac       <= 7'h00;
                            busy_cnt <= CLEAR_LOAD;
                        end
                        INS_CLEAR: begin
                            ac         <= 7'h00;
                            id         <= 1'b1;
                            busy_cnt   <= CLEAR_LOAD;
                            clr_active <= 1'b1;
                            clr_idx    <= 7'h00;
                        end
                        default: ;
                    endcase
                end else if (!cmd_rw) begin
                    ac       <= ac_step(ac, id);
                    busy_cnt <= BUSY_LOAD;
                end else if (cmd_rs && !bf) begin
                    ac       <= ac_step(ac, id);
                    busy_cnt <= BUSY_LOAD;
                end
            end
        end
    end

    // DDRAM bus port: the clear sweep owns it while running, otherwise it follows AC
    always_comb begin
        ram_we    = 1'b0;
        ram_idx   = ddram_index(ac);
        ram_wdata = cmd;
        if (clr_active) begin
            ram_we    = 1'b1;
            ram_idx   = clr_idx;
            ram_wdata = SPACE_CODE;
        end else if ((state == EXEC) && cmd_rs && !cmd_rw && !bf) begin
            ram_we = 1'b1;
        end
    end

    assign rd_byte = rs_q2 ? ram_rdata : {bf, ac};

    // Read data drive: high nibble first, low nibble on the second pulse in 4-bit mode
    always_ff @(posedge clk) begin
        if (rst) begin
            db_oe <= 1'b0;
            db_o  <= 4'h0;
        end else begin
            db_oe <= e_q2 & rw_q2;
            if (e_q2 && rw_q2)
                db_o <= nib_low ? rd_byte[3:0] : rd_byte[7:4];
            else
                db_o <= 4'h0;
        end
    end

    lcd1602_ddram u_ddram (
        .clk      (clk),
        .rst      (rst),
        .we       (ram_we),
        .idx      (ram_idx),
        .wdata    (ram_wdata),
        .rdata    (ram_rdata),
        .dbg_idx  (ddram_index(dbg_addr)),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed bench for lcd1602_responder: drives E/RS/RW/DB transfers and checks
// AC/BF readback, DDRAM mirror contents and the violation flag.
module tb_lcd1602_responder;

    localparam int BUSY  = 80;
    localparam int CLEAR = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs = 1'b0;
    logic       rw = 1'b0;
    logic       e = 1'b0;
    logic [3:0] db_i = 4'h0;
    logic [3:0] db_o;
    logic       db_oe;
    logic [6:0] dbg_addr = 7'h00;
    logic [7:0] dbg_data;
    logic       viol;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0] rd;
    logic [3:0] rn;
    logic       oe_seen;

    lcd1602_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs       (rs),
        .rw       (rw),
        .e        (e),
        .db_i     (db_i),
        .db_o     (db_o),
        .db_oe    (db_oe),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .viol     (viol)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got=%02h expected=%02h", tag, got, exp);
        end
    endtask

    // One E pulse; returns the nibble and output enable seen while E is high
    task automatic applyStimulus(input logic rs_v, input logic rw_v, input logic [3:0] nib,
                                 output logic [3:0] rd_nib, output logic oe);
        @(negedge clk);
        rs = rs_v; rw = rw_v; db_i = nib;
        repeat (2) @(negedge clk);
        e = 1'b1;
        repeat (6) @(negedge clk);
        rd_nib = db_o;
        oe     = db_oe;
        e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic write8(input logic rs_v, input logic [3:0] nib);
        logic [3:0] n; logic o;
        applyStimulus(rs_v, 1'b0, nib, n, o);
    endtask

    task automatic write4(input logic rs_v, input logic [7:0] b);
        logic [3:0] n; logic o;
        applyStimulus(rs_v, 1'b0, b[7:4], n, o);
        applyStimulus(rs_v, 1'b0, b[3:0], n, o);
    endtask

    task automatic read8(input logic rs_v, output logic [3:0] nib);
        logic o;
        applyStimulus(rs_v, 1'b1, 4'h0, nib, o);
    endtask

    task automatic read4(input logic rs_v, output logic [7:0] b, output logic oe);
        logic [3:0] hi, lo; logic o1, o2;
        applyStimulus(rs_v, 1'b1, 4'h0, hi, o1);
        applyStimulus(rs_v, 1'b1, 4'h0, lo, o2);
        b  = {hi, lo};
        oe = o1 & o2;
    endtask

    task automatic wait_ready(input int n);
        repeat (n + 10) @(negedge clk);
    endtask

    task automatic check_dbg(input string tag, input logic [6:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        repeat (2) @(negedge clk);
        checkOutput(tag, dbg_data, exp);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_db_oe", {7'h0, db_oe}, 8'h00);
        checkOutput("rst_db_o", {4'h0, db_o}, 8'h00);
        checkOutput("rst_dbg_data", dbg_data, 8'h00);
        checkOutput("rst_viol", {7'h0, viol}, 8'h00);
        rst = 1'b0;
        read8(1'b0, rn);
        checkOutput("rst_bf_ac_hi", {4'h0, rn}, 8'h00);

        // initialisation into 4-bit mode
        write8(1'b0, 4'h3); wait_ready(BUSY);
        write8(1'b0, 4'h3); wait_ready(BUSY);
        write8(1'b0, 4'h3); wait_ready(BUSY);
        write8(1'b0, 4'h2); wait_ready(BUSY);
        write4(1'b0, 8'h28); wait_ready(BUSY);

        // nibble-paired set address and data write
        write4(1'b0, 8'h80); wait_ready(BUSY);
        write4(1'b1, 8'h41); wait_ready(BUSY);
        check_dbg("ddram_00_A", 7'h00, 8'h41);
        read4(1'b0, rd, oe_seen);
        checkOutput("ac_after_A", rd, 8'h01);
        checkOutput("read_db_oe", {7'h0, oe_seen}, 8'h01);
        checkOutput("idle_db_oe", {7'h0, db_oe}, 8'h00);
        checkOutput("viol_clean", {7'h0, viol}, 8'h00);

        // line 1 end wraps into line 2
        write4(1'b0, 8'hA7); wait_ready(BUSY);
        write4(1'b1, 8'h5A); wait_ready(BUSY);
        check_dbg("ddram_27", 7'h27, 8'h5A);
        read4(1'b0, rd, oe_seen);
        checkOutput("ac_wrap_27_40", rd, 8'h40);

        // decrement mode wraps 0x00 -> 0x67 -> 0x66
        write4(1'b0, 8'h04); wait_ready(BUSY);
        write4(1'b0, 8'h80); wait_ready(BUSY);
        write4(1'b1, 8'h33); wait_ready(BUSY);
        read4(1'b0, rd, oe_seen);
        checkOutput("ac_wrap_00_67", rd, 8'h67);
        write4(1'b1, 8'h44); wait_ready(BUSY);
        read4(1'b0, rd, oe_seen);
        checkOutput("ac_dec_66", rd, 8'h66);
        check_dbg("ddram_67", 7'h67, 8'h44);

        // cursor shifts, including 0x40 - 1 -> 0x27
        write4(1'b0, 8'h14); wait_ready(BUSY);
        read4(1'b0, rd, oe_seen);
        checkOutput("shift_right", rd, 8'h67);
        write4(1'b0, 8'hC0); wait_ready(BUSY);
        write4(1'b0, 8'h10); wait_ready(BUSY);
        read4(1'b0, rd, oe_seen);
        checkOutput("shift_left_40", rd, 8'h27);

        // data read returns DDRAM[AC] and steps AC
        write4(1'b0, 8'h06); wait_ready(BUSY);
        write4(1'b0, 8'h80); wait_ready(BUSY);
        read4(1'b1, rd, oe_seen);
        checkOutput("data_read_00", rd, 8'h33);
        wait_ready(BUSY);
        read4(1'b0, rd, oe_seen);
        checkOutput("ac_after_dread", rd, 8'h01);

        // clear: busy readback, write during sweep discarded, all spaces
        write4(1'b0, 8'h04); wait_ready(BUSY);
        write4(1'b0, 8'h01);
        read4(1'b0, rd, oe_seen);
        checkOutput("bf_during_clear", rd, 8'h80);
        checkOutput("viol_before_busy_wr", {7'h0, viol}, 8'h00);
        write4(1'b1, 8'h99);
        checkOutput("viol_busy_wr", {7'h0, viol}, 8'h01);
        wait_ready(CLEAR);
        read4(1'b0, rd, oe_seen);
        checkOutput("ac_after_clear", rd, 8'h00);
        for (int a = 0; a < 128; a++) begin
            if ((a <= 8'h27) || ((a >= 8'h40) && (a <= 8'h67)))
                check_dbg($sformatf("clear_%02h", a), a[6:0], 8'h20);
        end
        write4(1'b1, 8'h55); wait_ready(BUSY);
        read4(1'b0, rd, oe_seen);
        checkOutput("clear_sets_id", rd, 8'h01);

        // reset keeps DDRAM; illegal set address flags viol and zeroes AC
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("viol_after_rst", {7'h0, viol}, 8'h00);
        rst = 1'b0;
        check_dbg("ddram_kept", 7'h00, 8'h55);
        write8(1'b0, 4'hC); wait_ready(BUSY);
        read8(1'b0, rn);
        checkOutput("ac8_40_hi", {4'h0, rn}, 8'h04);
        write8(1'b0, 4'hE); wait_ready(BUSY);
        write8(1'b1, 4'h5); wait_ready(BUSY);
        check_dbg("ddram_60", 7'h60, 8'h50);
        checkOutput("viol_pre_bad", {7'h0, viol}, 8'h00);
        write8(1'b0, 4'hB); wait_ready(BUSY);
        checkOutput("viol_bad_addr", {7'h0, viol}, 8'h01);
        read8(1'b0, rn);
        checkOutput("ac_bad_addr_hi", {4'h0, rn}, 8'h00);

        // reset in the middle of a clear sweep aborts it
        write8(1'b0, 4'h2); wait_ready(BUSY);
        write4(1'b0, 8'h01);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        read8(1'b0, rn);
        checkOutput("bf_after_rst_clear", {4'h0, rn}, 8'h00);
        checkOutput("viol_after_rst2", {7'h0, viol}, 8'h00);
        check_dbg("sweep_started", 7'h00, 8'h20);
        check_dbg("sweep_aborted", 7'h60, 8'h50);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/lcd1602_responder.md
LCD1602_RESPONDER -- requirements
Module: lcd1602_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 2000: clk cycles BF stays high after a normal instruction or data transfer.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 76000: BF cycles after Clear/Return Home; legal only if CLEAR_CYCLES >= 80.
REQ-003 SHALL have port clk  in  1  single clock, one clock domain.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port rs  in  1  register select, 0 = instruction, 1 = data.
REQ-006 SHALL have port rw  in  1  1 = read, 0 = write.
REQ-007 SHALL have port e  in  1  bus enable strobe, asynchronous to clk.
REQ-008 SHALL have port db_i  in  4  DB7..DB4 sampled from the bus.
REQ-009 SHALL have port db_o  out  4  DB7..DB4 driven on reads.
REQ-010 SHALL have port db_oe  out  1  output enable for db_o.
REQ-011 SHALL have port dbg_addr  in  7  DDRAM mirror read address.
REQ-012 SHALL have port dbg_data  out  8  DDRAM[dbg_addr], 1-cycle registered latency.
REQ-013 SHALL have port viol  out  1  sticky flag: write while busy, or illegal DDRAM address.

Function
REQ-014 SHALL pass e, rs, rw and db_i through a 2-flop synchronizer; all decode SHALL use the synchronized signals.
REQ-015 SHALL sample rs/rw/db on the cycle the synchronized e falls; a transfer is complete on that falling edge.
REQ-016 SHALL start in 8-bit mode (DL=1): each E pulse is a full byte {db_i, 4'h0}.
REQ-017 In 4-bit mode, SHALL take the high nibble on the first E pulse and the low nibble on the second; the phase toggle SHALL be cleared by Function Set.
REQ-018 SHALL use bus FSM states: WAIT_E, E_HIGH, EXEC, then back to WAIT_E; EXEC lasts exactly 1 cycle after byte completion.
REQ-019 Clear (0x01) SHALL set AC=0, I/D=1, write 0x20 to all 80 DDRAM locations (1 per cycle in a CLEAR sweep), and set BF for CLEAR_CYCLES.
REQ-020 Return Home (0x02-0x03) SHALL set AC=0 and BF for CLEAR_CYCLES.
REQ-021 Entry Mode (0x04-0x07) SHALL store I/D = bit1; the shift bit SHALL be ignored.
REQ-022 Display Control (0x08-0x0F) SHALL store D/C/B bits.
REQ-023 Cursor Shift (0x10-0x1F) SHALL step AC by ±1 when S/C=0, per R/L; display shift SHALL be a no-op.
REQ-024 Function Set (0x20-0x3F) SHALL load DL = bit4.
REQ-025 Set CGRAM (0x40-0x7F) SHALL be accepted and otherwise ignored.
REQ-026 Set DDRAM (0x80-0xFF) SHALL load AC = data[6:0]; an address in 0x28-0x3F or >0x67 SHALL load AC=0 and set viol.
REQ-027 A data write SHALL store DDRAM[AC] = byte, then step AC by I/D.
REQ-028 AC stepping SHALL use legal addresses 0x00-0x27 and 0x40-0x67, wrapping 0x27+1→0x40, 0x67+1→0x00, 0x00-1→0x67, 0x40-1→0x27.
REQ-029 Each executed write or data read SHALL set BF for BUSY_CYCLES; a BF/AC read SHALL never set BF.
REQ-030 A write arriving with BF=1 SHALL be discarded and SHALL set viol; BF/AC reads SHALL be served while busy.
REQ-031 Reads SHALL drive db_oe=1 while synchronized e=1 and rw=1, with db_o = high nibble, then low nibble in 4-bit mode.
REQ-032 A BF/AC read SHALL return {BF, AC}; a data read SHALL return DDRAM[AC] and step AC after the final nibble.
REQ-033 An E pulse during the CLEAR sweep SHALL be treated as a write while busy.
REQ-034 The bus-side DDRAM port SHALL take priority over nothing else; the dbg port SHALL be independent and read-only.

Reset
REQ-035 rst SHALL set: DL=1, nibble phase=high, AC=0, I/D=1, D/C/B=0, BF=0, viol=0, FSM=WAIT_E, db_oe=0, db_o=0, dbg_data=0.
REQ-036 rst SHALL leave DDRAM contents unchanged; asserting rst mid-sweep or mid-busy SHALL abort immediately.

Structure
REQ-037 Package lcd1602_pkg SHALL hold: opcode masks, DDRAM bounds (0x27, 0x40, 0x67), FSM state enum, and the space code 0x20.
REQ-038 DDRAM SHALL be a sub-module lcd1602_ddram: 80x8, one write/read port plus one read-only port.

Verification
REQ-039 Init: 3 single pulses of 0x3, then 0x2, then 0x28 as nibbles → DL=0, next transfers nibble-paired.
REQ-040 Write 0x80, then data 'A' (0x41) → dbg_addr 0x00 reads 0x41 and AC reads back 0x01 via a BF/AC read.
REQ-041 Set DDRAM 0xA7 (AC=0x27), write data → AC becomes 0x40; with I/D=0 at AC 0x00, a write → AC becomes 0x67.
REQ-042 Clear → BF=1 for CLEAR_CYCLES, all 80 locations read 0x20, AC=0.
REQ-043 Write data during BF=1 → DDRAM unchanged and viol=1; a BF/AC read during busy → BF bit=1.
REQ-044 Set DDRAM 0xB0 → AC=0 and viol=1; rst mid-clear → BF=0 and FSM idle the next cycle.
